pll_lock_sequencer: RTL

- Consumer and controller of the PLL's lock/reset interface. It watches the asynchronous PLL lock output and drives the PLL reset input.
- It sequences PLL reset, waits for lock, and qualifies lock stability. It then releases a system reset for logic clocked by the PLL output.
- On lock loss it re-locks the PLL. After repeated lock timeouts it raises a fault.
- Runs on the 50 MHz board reference clock, which also feeds the PLL, so the block keeps running while the PLL is unlocked.

---
 rtl/pll_lock_sequencer_pkg.sv | 23 ++
 rtl/pll_lock_sequencer_cdc_sync_bit.sv | 21 ++
 rtl/pll_lock_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_pkg.sv
// Shared definitions for the PLL lock sequencer: state codes, counter limits
// and elaboration-time helpers.
package pll_seq_pkg;

   localparam int unsigned ST_W = 3;

   localparam logic [ST_W-1:0] RESET_PLL = 3'd0;
   localparam logic [ST_W-1:0] WAIT_LOCK = 3'd1;
   localparam logic [ST_W-1:0] STABILIZE = 3'd2;
   localparam logic [ST_W-1:0] RUN       = 3'd3;
   localparam logic [ST_W-1:0] FAULT     = 3'd4;

   localparam logic [7:0] LOCK_CNT_MAX = 8'd255;

   // Largest of three values; sizes the shared timer.
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_lock_sequencer_cdc_sync_bit.sv
// Two-flop single-bit synchronizer with asynchronous active-low clear.
module cdc_sync_bit (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, waits for and qualifies lock, then releases the
// PLL-domain reset; relocks on lock loss and faults after repeated timeouts.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 50000,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       pll_lock,
   input  logic       clr_fault,
   output logic       pll_rst,
   output logic       rst_out_n,
   output logic       sys_ready,
   output logic       fault,
   output logic [7:0] lock_lost_cnt
);

   localparam int unsigned TMR_W = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES)) + 1;
   localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);

   logic             lock_s;
   logic [ST_W-1:0]  state, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic [RTY_W-1:0] retry_cnt, retry_nxt, retry_inc;
   logic [7:0]       lost_nxt;

   cdc_sync_bit u_lock_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (pll_lock),
      .q     (lock_s)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= RESET_PLL;
         timer         <= '0;
         retry_cnt     <= '0;
         lock_lost_cnt <= 8'd0;
      end else begin
         state         <= state_nxt;
         timer         <= timer_nxt;
         retry_cnt     <= retry_nxt;
         lock_lost_cnt <= lost_nxt;
      end
   end

   // Timer is held at zero in RUN and FAULT, where no terminal count applies.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer + TMR_W'(1);
      retry_nxt = retry_cnt;
      retry_inc = retry_cnt + RTY_W'(1);
      lost_nxt  = lock_lost_cnt;
      case (state)
         RESET_PLL: begin
            if (timer == TMR_W'(PLL_RST_CYCLES - 1)) begin
               state_nxt = WAIT_LOCK;
               timer_nxt = '0;
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_nxt = STABILIZE;
               timer_nxt = '0;
            end else if (timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
               retry_nxt = retry_inc;
               state_nxt = (retry_inc == RTY_W'(MAX_RETRIES)) ? FAULT : RESET_PLL;
               timer_nxt = '0;
            end
         end
         STABILIZE: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
               timer_nxt = '0;
            end else if (timer == TMR_W'(STABLE_CYCLES - 1)) begin
               state_nxt = RUN;
               retry_nxt = '0;
               timer_nxt = '0;
            end
         end
         RUN: begin
            timer_nxt = '0;
            if (!lock_s) begin
               state_nxt = RESET_PLL;
               if (lock_lost_cnt != LOCK_CNT_MAX) begin
                  lost_nxt = lock_lost_cnt + 8'd1;
               end
            end
         end
         FAULT: begin
            timer_nxt = '0;
            if (clr_fault) begin
               state_nxt = RESET_PLL;
               retry_nxt = '0;
            end
         end
         default: begin
            state_nxt = RESET_PLL;
            timer_nxt = '0;
         end
      endcase
   end

   // Outputs decode the next state so they change on the transition edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pll_rst   <= 1'b1;
         rst_out_n <= 1'b0;
         sys_ready <= 1'b0;
         fault     <= 1'b0;
      end else begin
         pll_rst   <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
         rst_out_n <= (state_nxt == RUN);
         sys_ready <= (state_nxt == RUN);
         fault     <= (state_nxt == FAULT);
      end
   end

endmodule
